// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue_pkg
// Brief    : Shared RV32I(M) decode definitions: opcodes, the decoded
//            instruction record and immediate extraction helpers.
// Revision : 1.0 - initial release
// ============================================================================
package decode_queue_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // funct7 values that qualify register-register encodings
    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    // SYSTEM instructions are only recognised as exact words
    localparam logic [31:0] c_ECALL  = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK = 32'h0010_0073;

    // One flag per recognised mnemonic; all zero means illegal
    typedef struct packed {
        logic lui, auipc, jal, jalr;
        logic beq, bne, blt, bge, bltu, bgeu;
        logic lb, lh, lw, lbu, lhu;
        logic sb, sh, sw;
        logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
        logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
        logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
        logic fence, ecall, ebreak;
    } op_flags_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        op_flags_t   op;
        logic        is_load;
        logic        is_store;
        logic        is_conditional_jump;
        logic        illegal;
    } instructions;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_queue_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_decoder
// Brief    : Purely combinational RV32I(M) decoder producing the shared
//            instruction record plus a may-jump hint.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decoder
    import decode_queue_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output instructions dec,
    output logic        may_jump
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    op_flags_t  w_op;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // Identify the mnemonic; unrecognised encodings leave every flag clear
    always_comb begin
        w_op = '0;
        case (w_opcode)
            OP_LUI:   w_op.lui   = 1'b1;
            OP_AUIPC: w_op.auipc = 1'b1;
            OP_JAL:   w_op.jal   = 1'b1;
            OP_JALR:  w_op.jalr  = (w_funct3 == 3'b000);
            OP_BRANCH: begin
                case (w_funct3)
                    3'b000:  w_op.beq  = 1'b1;
                    3'b001:  w_op.bne  = 1'b1;
                    3'b100:  w_op.blt  = 1'b1;
                    3'b101:  w_op.bge  = 1'b1;
                    3'b110:  w_op.bltu = 1'b1;
                    3'b111:  w_op.bgeu = 1'b1;
                    default: ;
                endcase
            end
            OP_LOAD: begin
                case (w_funct3)
                    3'b000:  w_op.lb  = 1'b1;
                    3'b001:  w_op.lh  = 1'b1;
                    3'b010:  w_op.lw  = 1'b1;
                    3'b100:  w_op.lbu = 1'b1;
                    3'b101:  w_op.lhu = 1'b1;
                    default: ;
                endcase
            end
            OP_STORE: begin
                case (w_funct3)
                    3'b000:  w_op.sb = 1'b1;
                    3'b001:  w_op.sh = 1'b1;
                    3'b010:  w_op.sw = 1'b1;
                    default: ;
                endcase
            end
            OP_IMM: begin
                case (w_funct3)
                    3'b000: w_op.addi  = 1'b1;
                    3'b001: w_op.slli  = (w_funct7 == c_F7_BASE);
                    3'b010: w_op.slti  = 1'b1;
                    3'b011: w_op.sltiu = 1'b1;
                    3'b100: w_op.xori  = 1'b1;
                    3'b101: begin
                        w_op.srli = (w_funct7 == c_F7_BASE);
                        w_op.srai = (w_funct7 == c_F7_ALT);
                    end
                    3'b110:  w_op.ori  = 1'b1;
                    default: w_op.andi = 1'b1;
                endcase
            end
            OP_REG: begin
                case (w_funct7)
                    c_F7_BASE: begin
                        case (w_funct3)
                            3'b000:  w_op.add    = 1'b1;
                            3'b001:  w_op.sll    = 1'b1;
                            3'b010:  w_op.slt    = 1'b1;
                            3'b011:  w_op.sltu   = 1'b1;
                            3'b100:  w_op.xor_op = 1'b1;
                            3'b101:  w_op.srl    = 1'b1;
                            3'b110:  w_op.or_op  = 1'b1;
                            default: w_op.and_op = 1'b1;
                        endcase
                    end
                    c_F7_ALT: begin
                        case (w_funct3)
                            3'b000:  w_op.sub = 1'b1;
                            3'b101:  w_op.sra = 1'b1;
                            default: ;
                        endcase
                    end
                    c_F7_MULDIV: begin
                        // Without the M extension these fall through as illegal
                        if (ENABLE_M) begin
                            case (w_funct3)
                                3'b000:  w_op.mul    = 1'b1;
                                3'b001:  w_op.mulh   = 1'b1;
                                3'b010:  w_op.mulhsu = 1'b1;
                                3'b011:  w_op.mulhu  = 1'b1;
                                3'b100:  w_op.div    = 1'b1;
                                3'b101:  w_op.divu   = 1'b1;
                                3'b110:  w_op.rem    = 1'b1;
                                default: w_op.remu   = 1'b1;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
            OP_FENCE: w_op.fence = (w_funct3 == 3'b000);
            OP_SYSTEM: begin
                w_op.ecall  = (instr == c_ECALL);
                w_op.ebreak = (instr == c_EBREAK);
            end
            default: ;
        endcase
    end

    // Extract operand fields by format; register fields of formats that do
    // not carry them are zeroed, unknown opcodes keep raw fields and imm=0
    always_comb begin
        dec     = '0;
        dec.pc  = pc;
        dec.op  = w_op;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                dec.rs1 = '0;
                dec.rs2 = '0;
                dec.imm = imm_u(instr);
            end
            OP_JAL: begin
                dec.rs1 = '0;
                dec.rs2 = '0;
                dec.imm = imm_j(instr);
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
                dec.rs2 = '0;
                dec.imm = imm_i(instr);
            end
            OP_STORE: begin
                dec.rd  = '0;
                dec.imm = imm_s(instr);
            end
            OP_BRANCH: begin
                dec.rd  = '0;
                dec.imm = imm_b(instr);
            end
            default: ;
        endcase
        dec.is_load  = |{w_op.lb, w_op.lh, w_op.lw, w_op.lbu, w_op.lhu};
        dec.is_store = |{w_op.sb, w_op.sh, w_op.sw};
        dec.is_conditional_jump = |{w_op.beq, w_op.bne, w_op.blt,
                                    w_op.bge, w_op.bltu, w_op.bgeu};
        dec.illegal  = (w_op == '0);
    end

    assign may_jump = w_op.jal | w_op.jalr | dec.is_conditional_jump;

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Brief    : DEPTH-entry instruction FIFO feeding a registered RV32I(M)
//            decode stage, valid/ready on both sides, with flush.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output instructions                  out_instr,
    output logic                         out_may_jump,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    instructions      r_out_instr;
    logic             r_out_may_jump;

    logic             w_push;
    logic             w_pop;
    instructions      w_dec;
    logic             w_may_jump;

    // in_ready looks only at the occupancy so out_ready never reaches it
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);

    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_may_jump = r_out_may_jump;
    assign count        = r_count;

    // Decode the FIFO head; result is captured only when it is popped
    rv_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .instr    (r_mem_instr[r_rd_ptr]),
        .pc       (r_mem_pc[r_rd_ptr]),
        .dec      (w_dec),
        .may_jump (w_may_jump)
    );

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem_pc[r_wr_ptr]    <= in_pc;
            r_mem_instr[r_wr_ptr] <= in_instr;
        end
    end

    // Pointers and occupancy; flush and reset discard everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: load on pop, drop valid once consumed, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_may_jump <= 1'b0;
        end else if (flush) begin
            r_out_valid    <= 1'b0;
        end else if (w_pop) begin
            r_out_valid    <= 1'b1;
            r_out_instr    <= w_dec;
            r_out_may_jump <= w_may_jump;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

endmodule
`default_nettype wire
